// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbiter-mux with one registered output stage.
// Define RR_ARB_MUX_FIXED_PRIO_EN for lowest-index-wins arbitration.
module rr_arb_mux #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CHW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [CHW-1:0]     out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [CHW-1:0]   gnt;
    logic [WIDTH-1:0] sel_data;
    logic             any;
    logic             can_accept;
    logic             accept;

    assign any        = |in_valid;
    assign can_accept = !out_valid || out_ready;
    assign accept     = any && can_accept && !rst;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) gnt = CHW'(i);
        end
    end
`else
    logic [CHW-1:0] ptr;
    logic [CHW-1:0] idx;

    // Scan from the far end back so the first hit after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CHW'((int'(ptr) + i) % NCH);
            if (in_valid[idx]) gnt = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= CHW'((int'(gnt) + 1) % NCH);
        end
    end
`endif

    always_comb begin
        sel_data = '0;
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == CHW'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (WIDTH=16, NCH=4).
// Fixed-priority checks run when RR_ARB_MUX_FIXED_PRIO_EN is defined.
module tb_rr_arb_mux;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int CHW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CHW-1:0]       out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        in_data   = '0;
        for (int i = 0; i < NCH; i++) set_ch(i, 16'hA000 + 16'(i));

        // reset with all channels requesting
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_ch", 32'(out_ch), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        settle();

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
        chk("fp_first_grant", 32'(in_ready), 32'h1);
        in_valid = 4'b1010;
        settle();
        for (int k = 0; k < 6; k++) begin
            chk("fp_in_ready", 32'(in_ready), 32'h2);
            step();
            chk("fp_out_valid", 32'(out_valid), 32'h1);
            chk("fp_out_ch", 32'(out_ch), 32'h1);
            chk("fp_out_data", 32'(out_data), 32'hA001);
        end
`else
        chk("first_grant", 32'(in_ready), 32'h1);

        // round robin, one beat per cycle
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_ch", 32'(out_ch), 32'(k % 4));
            chk("rr_out_data", 32'(out_data), 32'hA000 + 32'(k % 4));
            chk("rr_in_ready", 32'(in_ready), 32'h1 << ((k + 1) % 4));
        end

        // lone ch2 request wins although ptr=1
        in_valid = 4'b0100;
        set_ch(2, 16'h1234);
        settle();
        chk("lone_in_ready", 32'(in_ready), 32'h4);
        step();
        chk("bp_out_ch0", 32'(out_ch), 32'h2);
        chk("bp_out_data0", 32'(out_data), 32'h1234);

        // backpressure holds the beat
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_ch", 32'(out_ch), 32'h2);
            chk("bp_out_data", 32'(out_data), 32'h1234);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(in_ready), 32'h8);
        step();
        chk("bp_next_ch", 32'(out_ch), 32'h3);
        chk("bp_next_data", 32'(out_data), 32'hA003);

        // drive ptr to 3, then sparse request on ch1
        in_valid = 4'b0100;
        step();
        chk("sp_pre_ch", 32'(out_ch), 32'h2);
        in_valid = 4'b0010;
        set_ch(1, 16'hBEEF);
        settle();
        chk("sp_in_ready", 32'(in_ready), 32'h2);
        step();
        chk("sp_out_ch", 32'(out_ch), 32'h1);
        chk("sp_out_data", 32'(out_data), 32'hBEEF);
        in_valid = 4'hF;
        settle();
        chk("sp_ptr2", 32'(in_ready), 32'h4);

        // no requests: drain, ptr unchanged
        in_valid = 4'h0;
        settle();
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("idle_drain", 32'(out_valid), 32'h0);
        in_valid = 4'hF;
        settle();
        chk("idle_ptr_kept", 32'(in_ready), 32'h4);

        // reset while a beat is held
        in_valid  = 4'b0100;
        set_ch(2, 16'h5555);
        out_ready = 1'b0;
        step();
        chk("mr_held_data", 32'(out_data), 32'h5555);
        in_valid = 4'h0;
        step();
        chk("mr_held_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_out_data", 32'(out_data), 32'h0);
        chk("mr_out_ch", 32'(out_ch), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        settle();
        chk("mr_ptr0", 32'(in_ready), 32'h1);
        in_valid = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mr_no_stale", 32'(out_valid), 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 16, data width per channel in bits (1..64).
- REQ-002: The block SHALL have parameter NCH, default 4, number of input channels (2..16).
- REQ-003: The block SHALL have parameter CHW, default 2, channel-index width; it SHALL equal ceil(log2(NCH)).
- REQ-004: The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
- REQ-005: The block SHALL have port rst  input  1  reset, synchronous and active-high.
- REQ-006: The block SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-007: The block SHALL have port in_valid  input  NCH  per-channel request.
- REQ-008: The block SHALL have port in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- REQ-009: The block SHALL have port out_data  output  WIDTH  registered selected data.
- REQ-010: The block SHALL have port out_ch  output  CHW  index of the channel that supplied out_data.
- REQ-011: The block SHALL have port out_valid  output  1  out_data/out_ch hold a beat.
- REQ-012: The block SHALL have port out_ready  input  1  downstream accepts the beat.

Function
- REQ-013: The block SHALL hold one output register stage (out_data, out_ch, out_valid) and a priority pointer ptr[CHW-1:0].
- REQ-014: The block SHALL define can_accept = !out_valid | out_ready.
- REQ-015: The grant SHALL go to the first channel with in_valid high, searching ptr, ptr+1, ... and wrapping from NCH-1 to 0.
- REQ-016: in_ready[g] SHALL be high only for the granted channel g and only when can_accept; it is combinational from in_valid, ptr, out_valid and out_ready.
- REQ-017: When in_valid[g] & in_ready[g], on the next edge out_data SHALL be in_data[g], out_ch SHALL be g, out_valid SHALL be 1, and ptr SHALL be (g+1) mod NCH (latency 1 cycle).
- REQ-018: When out_valid & out_ready and no channel is accepted, out_valid SHALL clear on the next edge.
- REQ-019: When out_valid & !out_ready, out_data, out_ch and out_valid SHALL hold stable, and in_ready SHALL be all-zero.
- REQ-020: Simultaneous drain and accept SHALL give back-to-back beats, one beat per cycle sustained.
- REQ-021: With no in_valid bit set, in_ready SHALL be zero and ptr SHALL be unchanged.
- REQ-022: A single requesting channel SHALL be granted regardless of ptr.
- REQ-023: in_valid deasserting without a handshake is legal; the block SHALL ignore it without error.

Reset
- REQ-024: When rst is high at a rising edge, out_valid SHALL be 0, out_data SHALL be 0, out_ch SHALL be 0 and ptr SHALL be 0.
- REQ-025: While rst is high, in_ready SHALL be all-zero.
- REQ-026: Reset asserted mid-transfer SHALL drop any held beat without it ever being presented as out_valid afterwards.

Configuration
- REQ-027: If macro RR_ARB_MUX_FIXED_PRIO_EN is defined, the grant SHALL be the lowest-index channel with in_valid high, and ptr SHALL be neither implemented nor updated.
- REQ-028: If RR_ARB_MUX_FIXED_PRIO_EN is undefined, round-robin arbitration per REQ-015 and REQ-017 SHALL apply.
- REQ-029: All other behaviour SHALL be identical with or without the macro.

Verification (WIDTH=16, NCH=4, macro undefined unless stated)
- REQ-030: The bench SHALL cover reset: rst=1 for 2 cycles with in_valid=4'hF -> in_ready=0, out_valid=0, out_ch=0; after release, the first grant is channel 0.
- REQ-031: The bench SHALL cover round-robin sequencing: in_valid=4'hF held, out_ready=1, in_data ch0..3 = 16'hA000/16'hA001/16'hA002/16'hA003 -> out_ch sequence 0,1,2,3,0, one beat per cycle, out_data matches channel.
- REQ-032: The bench SHALL cover backpressure: a beat of 16'h1234 from ch2 with out_ready=0 for 3 cycles -> out_data=16'h1234 and out_ch=2 held, in_ready=0 throughout; out_ready=1 -> drains, next grant is ch3 if valid.
- REQ-033: The bench SHALL cover a sparse request: after ptr=3, only in_valid[1]=1 with data 16'hBEEF -> ch1 granted, out_data=16'hBEEF next cycle, ptr becomes 2.
- REQ-034: The bench SHALL cover reset mid-operation: out_valid=1, out_ready=0 holding 16'h5555, then rst=1 for 1 cycle -> out_valid=0, out_data=0, ptr=0, and 16'h5555 is never delivered.
- REQ-035: The bench SHALL cover fixed priority: with RR_ARB_MUX_FIXED_PRIO_EN defined, in_valid=4'b1010 held and out_ready=1 -> out_ch=1 every cycle, and ch3 is never granted.
